// File: rtl/store_req_queue.sv
// rtl/store_req_queue.sv - in-order store/AMO request FIFO with empty-queue bypass
module store_req_queue #(
  parameter int unsigned DEPTH      = 2,
  parameter type         lsu_ctrl_t = logic [63:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  lsu_ctrl_t                  lsu_ctrl_i,
  output logic                       ready_o,
  output logic                       st_valid_o,
  output lsu_ctrl_t                  st_ctrl_o,
  input  logic                       pop_st_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  lsu_ctrl_t         mem_q [DEPTH];
  logic [PW-1:0]     rptr_q, wptr_q;
  logic [CW-1:0]     count_q;
  logic              empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // An empty queue with a same-cycle pop hands the request straight through
  assign push = valid_i && !full && !flush_i && !(empty && pop_st_i);
  assign pop  = pop_st_i && !empty && !flush_i;

  assign ready_o    = !full;
  assign st_valid_o = !flush_i && (!empty || valid_i);
  assign st_ctrl_o  = empty ? lsu_ctrl_i : mem_q[rptr_q];
  assign usage_o    = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= lsu_ctrl_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(valid_i && full && !flush_i));

  a_no_pop_when_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_st_i && empty && !valid_i && !flush_i));

endmodule

// File: doc/store_req_queue.md
Name: store_req_queue

Overview:
- Small in-order FIFO directly upstream of the store unit. Accepts store/AMO requests from the LSU issue path.
- Presents the oldest request to the store unit and holds it stable until the store unit pops it, including across TLB-miss and store-buffer-full stalls.
- Offers a zero-latency bypass when empty, so a request can be issued and popped in the same cycle.

Parameters:
DEPTH, 2, number of request entries; power of two, >= 2

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
flush_i  input  1  synchronous flush; discards all queued requests
valid_i  input  1  new store/AMO request from issue
lsu_ctrl_i  input  lsu_ctrl_t  request payload (vaddr, data, be, operator, trans_id, ...)
ready_o  output  1  queue can accept a request this cycle
st_valid_o  output  1  a request is presented to the store unit
st_ctrl_o  output  lsu_ctrl_t  presented (oldest) request
pop_st_i  input  1  store unit consumed the presented request
usage_o  output  $clog2(DEPTH+1)  number of stored entries

Behaviour:
- Reset: rptr=wptr=0, count=0, all entries cleared to '0.
  - Outputs after reset: ready_o=1, st_valid_o=valid_i, usage_o=0, st_ctrl_o=lsu_ctrl_i (bypass).
- Storage: DEPTH-entry array. rptr/wptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is the authoritative occupancy.
- empty = (count==0); full = (count==DEPTH); ready_o = !full (combinational, independent of pop_st_i).
- Presentation (combinational):
  - st_valid_o = !flush_i && (!empty || valid_i).
  - st_ctrl_o = empty ? lsu_ctrl_i : mem[rptr].
- Push condition: valid_i && !full && !flush_i && !(empty && pop_st_i).
  - Push writes mem[wptr] and increments wptr.
  - The excluded case is a bypass: the request is consumed in the cycle it arrives and is never stored.
- Pop condition: pop_st_i && !empty && !flush_i. Pop increments rptr.
  - pop_st_i while empty and valid_i=1 is the bypass case above: no pointer change.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged and moves both pointers.
- Full:
  - valid_i && full is a protocol violation. The request is dropped, state is unchanged, and a simulation assertion fires.
  - pop_st_i while full is legal; ready_o rises the cycle after the pop.
- pop_st_i while empty && !valid_i: ignored, with a simulation assertion.
- Stability: while st_valid_o=1 and pop_st_i=0, st_ctrl_o does not change except via flush.
  - The head entry is never overwritten, because push targets wptr != rptr unless empty.
- Flush:
  - In the flush cycle, push and pop are suppressed and st_valid_o=0.
  - Next cycle: rptr=wptr=0, count=0, usage_o=0, ready_o=1. Array contents are not cleared.
  - flush_i has priority over valid_i and pop_st_i.
- Reset mid-operation: asynchronous. All state returns to reset values immediately; any in-flight request is lost.
- usage_o = count, registered, with no combinational path from inputs.
- Ordering: strict FIFO. Entries are presented to the store unit in acceptance order; the bypass is only permitted when empty, so order is preserved.

Test Plan:
- Bypass: empty queue, valid_i=1 with trans_id=3 and pop_st_i=1 in the same cycle.
  - Same cycle: st_valid_o=1, st_ctrl_o.trans_id=3.
  - Next cycle: usage_o=0, no entry stored.
- Stall hold: empty queue, valid_i=1 with vaddr=0x1000 and pop_st_i=0; then pop_st_i=0 for 3 cycles.
  - usage_o=1.
  - st_ctrl_o.vaddr=0x1000 on every cycle.
  - Pop in the 4th cycle, then usage_o=0.
- Fill/full (DEPTH=2): push trans_id 1, then 2, with no pops.
  - ready_o=0 and usage_o=2.
  - Pop 1 -> head becomes trans_id 2 and ready_o=1 in the next cycle.
- Wrap-around with simultaneous push and pop: stream trans_id 1..6, one push per cycle, popping every cycle from cycle 2.
  - Pops observe 1..6 in order.
  - usage_o stays 1.
  - Pointers wrap at least twice.
- Flush: usage_o=2, then flush_i=1 together with valid_i=1 and pop_st_i=1.
  - Flush cycle: st_valid_o=0.
  - Next cycle: usage_o=0, ready_o=1, and st_ctrl_o follows lsu_ctrl_i.
- Async reset mid-stream: assert rst_ni=0 with usage_o=1 and off the clock edge.
  - Immediately: usage_o=0, ready_o=1, st_valid_o=valid_i.
